// File: rtl/pixel_sensor_ctrl.sv
// rtl/pixel_sensor_ctrl.sv - pixel array sequencer: erase, expose, ramp convert, row readout
module pixel_sensor_ctrl #(
    parameter int N_ROWS    = 2,
    parameter int C_ERASE   = 5,
    parameter int C_CONVERT = 256
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [7:0]                                  expose_time,
    output logic                                        erase,
    output logic                                        expose,
    output logic                                        convert,
    output logic                                        read,
    output logic [(N_ROWS > 1 ? $clog2(N_ROWS) : 1)-1:0] row_sel,
    output logic [7:0]                                  counter,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        busy,
    output logic                                        frame_done
);

    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [8:0]       ERASE_LAST = 9'(C_ERASE - 1);
    localparam logic [8:0]       CONV_LAST  = 9'(C_CONVERT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       phase_q, phase_d;     // cycles spent in the current timed phase
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       exp_len_q, exp_len_d; // exposure length frozen for the frame
    logic             done_q, done_d;

    // State and counter registers; reset drops straight to IDLE with no frame_done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            row_q     <= '0;
            exp_len_q <= 8'd1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            row_q     <= row_d;
            exp_len_q <= exp_len_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: each timed phase exits when its counter reaches the last cycle
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        row_d     = row_q;
        exp_len_d = exp_len_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                row_d   = '0;
                if (start) begin
                    // A zero exposure still yields one expose cycle
                    exp_len_d = (expose_time == 8'd0) ? 8'd1 : expose_time;
                    state_d   = S_ERASE;
                end
            end
            S_ERASE: begin
                if (phase_q == ERASE_LAST) begin
                    phase_d = '0;
                    state_d = S_EXPOSE;
                end else begin
                    phase_d = phase_q + 9'd1;
                end
            end
            S_EXPOSE: begin
                if (phase_q == ({1'b0, exp_len_q} - 9'd1)) begin
                    phase_d = '0;
                    state_d = S_CONVERT;
                end else begin
                    phase_d = phase_q + 9'd1;
                end
            end
            S_CONVERT: begin
                if (phase_q == CONV_LAST) begin
                    phase_d = '0;
                    row_d   = '0;
                    state_d = S_READ;
                end else begin
                    phase_d = phase_q + 9'd1;
                end
            end
            S_READ: begin
                if (out_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded purely from registered state and counters
    always_comb begin
        erase      = (state_q == S_ERASE);
        expose     = (state_q == S_EXPOSE);
        convert    = (state_q == S_CONVERT);
        read       = (state_q == S_READ);
        out_valid  = (state_q == S_READ);
        busy       = (state_q != S_IDLE);
        frame_done = done_q;
        row_sel    = (state_q == S_READ) ? row_q : '0;
        counter    = 8'd0;
        if (state_q == S_CONVERT) begin
            // Ramp saturates at full scale rather than wrapping
            counter = (phase_q > 9'd255) ? 8'hFF : phase_q[7:0];
        end
    end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// tb/tb_pixel_sensor_ctrl.sv - directed self-checking bench for pixel_sensor_ctrl
module tb_pixel_sensor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] expose_time;
    logic       erase, expose, convert, read;
    logic [0:0] row_sel;
    logic [7:0] counter;
    logic       out_valid, out_ready, busy, frame_done;

    int checks = 0;
    int errors = 0;

    pixel_sensor_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .expose_time(expose_time),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .row_sel(row_sel), .counter(counter), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Every cycle: strobes one-hot-or-none, and busy exactly when a non-IDLE strobe is up
    always @(negedge clk) begin
        checks = checks + 1;
        if (!$onehot0({erase, expose, convert, read}) || (busy !== (erase | expose | convert | read))) begin
            errors = errors + 1;
            $display("FAIL onehot_busy t=%0t strobes=%b busy=%b", $time, {erase, expose, convert, read}, busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame and compares every output each cycle against the hand-derived timeline
    task automatic run_frame(input logic [7:0] e_in, input int stall, input bit inject, input string name);
        int e, r, d;
        logic [16:0] exp_v, act_v;
        e = (e_in == 0) ? 1 : int'(e_in);
        r = 6 + e + 256;
        d = r + stall + 2;
        expose_time = e_in;
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= d + 3; t++) begin
            exp_v = '0;
            exp_v[16] = (t <= 5);
            exp_v[15] = (t >= 6 && t < 6 + e);
            exp_v[14] = (t >= 6 + e && t < r);
            exp_v[13] = (t >= r && t < d);
            exp_v[12] = (t >= r && t < d);
            exp_v[11] = (t < d);
            exp_v[10] = (t == d);
            exp_v[9]  = (t >= r + stall + 1 && t < d);
            exp_v[7:0] = (t >= 6 + e && t < r) ? 8'(t - 6 - e) : 8'd0;
            act_v = {erase, expose, convert, read, out_valid, busy, frame_done, row_sel, 1'b0, counter};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL %s t=%0d got=%h want=%h", name, t, act_v, exp_v);
            end
            out_ready = (t >= r && t < r + stall) ? 1'b0 : 1'b1;
            if (inject && t == 8) begin
                start = 1'b1;
                expose_time = 8'd50;
            end else begin
                start = 1'b0;
            end
            step();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        expose_time = 8'd10;
        out_ready = 1'b1;
        repeat (3) step();
        checks = checks + 1;
        if ({erase, expose, convert, read, out_valid, busy, frame_done, row_sel, counter} !== 16'd0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs got=%h want=0", {erase, expose, convert, read, out_valid, busy, frame_done, row_sel, counter});
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (2) step();
        checks = checks + 1;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL post_reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid_convert();
        int seen_done;
        expose_time = 8'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (115) step();
        checks = checks + 1;
        if (counter !== 8'd100 || convert !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL convert_100 counter=%0d convert=%b want=100,1", counter, convert);
        end
        #2 reset = 1'b1;
        #1;
        checks = checks + 1;
        if ({erase, expose, convert, read, out_valid, busy, frame_done, row_sel, counter} !== 16'd0) begin
            errors = errors + 1;
            $display("FAIL async_reset got=%h want=0", {erase, expose, convert, read, out_valid, busy, frame_done, row_sel, counter});
        end
        step();
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 300; i++) begin
            if (frame_done || busy) seen_done++;
            step();
        end
        checks = checks + 1;
        if (seen_done != 0) begin
            errors = errors + 1;
            $display("FAIL abort_no_done active_cycles=%0d want=0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int t, t_done;
        expose_time = 8'd3;
        start = 1'b1;
        step();
        t = 1;
        t_done = 0;
        while (t_done == 0 && t < 400) begin
            if (frame_done) t_done = t;
            else begin
                step();
                t++;
            end
        end
        checks = checks + 1;
        if (t_done != 267) begin
            errors = errors + 1;
            $display("FAIL b2b_done_cycle got=%0d want=267", t_done);
        end
        checks = checks + 1;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL b2b_idle_gap busy=%b want=0", busy);
        end
        step();
        start = 1'b0;
        checks = checks + 1;
        if (erase !== 1'b1 || busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL b2b_restart erase=%b busy=%b want=1,1", erase, busy);
        end
        t = 1;
        t_done = 0;
        while (t_done == 0 && t < 400) begin
            if (frame_done) t_done = t;
            else begin
                step();
                t++;
            end
        end
        checks = checks + 1;
        if (t_done != 267) begin
            errors = errors + 1;
            $display("FAIL b2b_second_done got=%0d want=267", t_done);
        end
        repeat (3) step();
        checks = checks + 1;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL b2b_final_idle busy=%b done=%b want=0,0", busy, frame_done);
        end
    endtask

    initial begin
        test_reset();
        run_frame(8'd10, 0, 1'b0, "frame_default");
        run_frame(8'd10, 3, 1'b0, "frame_stall");
        run_frame(8'd0, 0, 1'b0, "frame_zero_expose");
        run_frame(8'd10, 0, 1'b1, "frame_start_ignored");
        test_reset_mid_convert();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
